// File: rtl/dds_pkg.sv
// Shared defaults and state encoding for the DDS phase accumulator.
package dds_pkg;

    localparam int unsigned ACC_W_DEF  = 32;
    localparam int unsigned ADDR_W_DEF = 12;
    localparam int unsigned CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        BURST,
        STOPPING
    } dds_state_e;

endpackage

// File: rtl/dds_fword_hold.sv
// Frequency-word holding register: accepts a word via valid/ready and moves it to the
// active tuning word when the load strobe fires.
module dds_fword_hold
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [ACC_W-1:0] fword,
    input  logic             fword_vld,
    output logic             fword_rdy,
    input  logic             load,
    output logic [ACC_W-1:0] fword_act
);

    logic [ACC_W-1:0] hold_q;
    logic             hold_vld_q;
    logic [ACC_W-1:0] act_q;

    assign fword_rdy = !hold_vld_q;
    assign fword_act = act_q;

    // Accept needs an empty holder and load needs a full one, so they never collide.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            act_q      <= '0;
        end else if (load && hold_vld_q) begin
            act_q      <= hold_q;
            hold_vld_q <= 1'b0;
        end else if (fword_vld && !hold_vld_q) begin
            hold_q     <= fword;
            hold_vld_q <= 1'b1;
        end
    end

endmodule

// File: rtl/dds_phase_acc.sv
// DDS phase accumulator: phase-continuous frequency updates at wrap, offset ROM address,
// continuous or counted-burst operation.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int unsigned ACC_W  = ACC_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  burst_n,
    input  logic [ACC_W-1:0]  fword,
    input  logic              fword_vld,
    output logic              fword_rdy,
    input  logic [ADDR_W-1:0] poffs,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              addr_vld,
    output logic              q_vld,
    output logic              wrap,
    output logic              busy,
    output logic              done
);

    dds_state_e       state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [ACC_W-1:0] fword_act;
    logic [ACC_W:0]   sum;
    logic             running;
    logic             carry;
    logic             load;

    assign running = (state_q != IDLE);
    assign sum     = {1'b0, acc_q} + {1'b0, fword_act};
    assign carry   = running && sum[ACC_W];
    // In IDLE a new word takes effect at once; while running only at a period boundary.
    assign load    = !running || carry;
    assign busy    = running;

    dds_fword_hold #(
        .ACC_W (ACC_W)
    ) u_fword_hold (
        .clock     (clock),
        .rst_n     (rst_n),
        .fword     (fword),
        .fword_vld (fword_vld),
        .fword_rdy (fword_rdy),
        .load      (load),
        .fword_act (fword_act)
    );

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            rom_addr <= '0;
            addr_vld <= 1'b0;
            q_vld    <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rom_addr <= acc_q[ACC_W-1 -: ADDR_W] + poffs;
            addr_vld <= running;
            q_vld    <= addr_vld;
            wrap     <= carry;
            done     <= 1'b0;
            if (state_q == IDLE) begin
                acc_q <= '0;
                if (start) begin
                    if (burst_n == '0) begin
                        state_q <= RUN;
                    end else begin
                        state_q <= BURST;
                        cnt_q   <= burst_n;
                    end
                end
            end else if (stop && (fword_act == '0)) begin
                // A zero step never wraps, so stop must end the run immediately.
                state_q <= IDLE;
                acc_q   <= '0;
                done    <= 1'b1;
            end else if (carry && ((state_q == STOPPING) ||
                                   ((state_q == BURST) && (cnt_q == CNT_W'(1))))) begin
                state_q <= IDLE;
                acc_q   <= '0;
                done    <= 1'b1;
            end else begin
                acc_q <= sum[ACC_W-1:0];
                if (carry && (state_q == BURST)) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                if (stop) begin
                    state_q <= STOPPING;
                end
            end
        end
    end

endmodule

// File: tb/tb_dds_phase_acc.sv
// Self-checking bench for dds_phase_acc: directed scenarios plus randomized runs against a
// period-level reference model.
module tb_dds_phase_acc;

    localparam int ACC_W  = 32;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;
    localparam longint unsigned MODULUS = 64'h1_0000_0000;

    logic              clock = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [CNT_W-1:0]  burst_n = '0;
    logic [ACC_W-1:0]  fword = '0;
    logic              fword_vld = 1'b0;
    logic              fword_rdy;
    logic [ADDR_W-1:0] poffs = '0;
    logic [ADDR_W-1:0] rom_addr;
    logic              addr_vld;
    logic              q_vld;
    logic              wrap;
    logic              busy;
    logic              done;

    int total = 0;
    int bad = 0;
    int wraps_seen = 0;

    // Reference model: phase in turns of 2^32, periods remaining, pending word queue.
    bit                m_active;
    int                m_kind;      // 0 continuous, 1 burst, 2 finishing current period
    int                m_left;
    longint unsigned   m_phase;
    longint unsigned   m_step;
    longint unsigned   m_hold[$];
    logic [ADDR_W-1:0] e_addr;
    bit                e_addr_vld, e_q_vld, e_wrap, e_done;

    dds_phase_acc #(
        .ACC_W  (ACC_W),
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .burst_n   (burst_n),
        .fword     (fword),
        .fword_vld (fword_vld),
        .fword_rdy (fword_rdy),
        .poffs     (poffs),
        .rom_addr  (rom_addr),
        .addr_vld  (addr_vld),
        .q_vld     (q_vld),
        .wrap      (wrap),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    initial begin
        #3ms;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            if (bad <= 30) $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_kind = 0;
        m_left = 0;
        m_phase = 0;
        m_step = 0;
        m_hold.delete();
        e_addr = '0;
        e_addr_vld = 1'b0;
        e_q_vld = 1'b0;
        e_wrap = 1'b0;
        e_done = 1'b0;
    endtask

    task automatic model_edge(input bit i_start, input bit i_stop, input longint unsigned i_burst,
                              input longint unsigned i_fword, input bit i_vld,
                              input longint unsigned i_poffs);
        bit accept;
        bit was_active;
        bit carry;
        longint unsigned nxt;
        accept = i_vld && (m_hold.size() == 0);
        was_active = m_active;
        carry = 1'b0;
        e_addr = ADDR_W'(((m_phase >> (ACC_W - ADDR_W)) + i_poffs) % (1 << ADDR_W));
        e_q_vld = e_addr_vld;
        e_addr_vld = m_active;
        e_wrap = 1'b0;
        e_done = 1'b0;
        if (!m_active) begin
            m_phase = 0;
            if (i_start) begin
                m_active = 1'b1;
                m_kind = (i_burst == 0) ? 0 : 1;
                m_left = int'(i_burst);
            end
        end else if (i_stop && m_step == 0) begin
            m_active = 1'b0;
            e_done = 1'b1;
            m_phase = 0;
        end else begin
            nxt = m_phase + m_step;
            carry = (nxt >= MODULUS);
            e_wrap = carry;
            m_phase = nxt % MODULUS;
            if (carry && m_kind == 1) m_left--;
            if (carry && (m_kind == 2 || (m_kind == 1 && m_left == 0))) begin
                m_active = 1'b0;
                e_done = 1'b1;
                m_phase = 0;
            end else if (i_stop) begin
                m_kind = 2;
            end
        end
        if ((!was_active || carry) && m_hold.size() > 0) m_step = m_hold.pop_front();
        if (accept) m_hold.push_back(i_fword);
    endtask

    task automatic check_all();
        check("rom_addr", 32'(rom_addr), 32'(e_addr));
        check("addr_vld", 32'(addr_vld), 32'(e_addr_vld));
        check("q_vld", 32'(q_vld), 32'(e_q_vld));
        check("wrap", 32'(wrap), 32'(e_wrap));
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(e_done));
        check("fword_rdy", 32'(fword_rdy), 32'(m_hold.size() == 0));
    endtask

    task automatic step();
        bit c_start, c_stop, c_vld;
        longint unsigned c_burst, c_fword, c_poffs;
        c_start = start;
        c_stop = stop;
        c_vld = fword_vld;
        c_burst = longint'(burst_n);
        c_fword = longint'(fword);
        c_poffs = longint'(poffs);
        @(posedge clock);
        #1;
        model_edge(c_start, c_stop, c_burst, c_fword, c_vld, c_poffs);
        if (wrap === 1'b1) wraps_seen++;
        check_all();
    endtask

    task automatic push(input logic [ACC_W-1:0] w);
        fword = w;
        fword_vld = 1'b1;
        step();
        fword_vld = 1'b0;
    endtask

    task automatic pulse_start(input int b);
        burst_n = CNT_W'(b);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_idle(input int max, input string tag);
        for (int i = 0; i < max && busy === 1'b1; i++) step();
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int b;
        int stop_at;
        model_reset();
        #2 rst_n = 1'b0;
        #9;
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_addr_vld", 32'(addr_vld), 32'd0);
        check("rst_q_vld", 32'(q_vld), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fword_rdy", 32'(fword_rdy), 32'd1);
        rst_n = 1'b1;

        // Continuous at 2^20: one address per clock, one wrap per 4096 clocks.
        push(32'h0010_0000);
        step();
        wraps_seen = 0;
        pulse_start(0);
        run(4116);
        check("s1_wrap_count", 32'(wraps_seen), 32'd1);

        // Stop at address 2000, with a second start ignored while busy.
        for (int i = 0; i < 5000 && (m_phase >> 20) != 2000; i++) step();
        pulse_stop();
        run(5);
        pulse_start(5);
        wait_idle(5000, "s2_stop_timeout");

        // Phase offset 100.
        poffs = 12'd100;
        pulse_start(0);
        step();
        check("s3_first_addr", 32'(rom_addr), 32'd100);
        run(4200);
        pulse_stop();
        wait_idle(5000, "s3_stop_timeout");
        poffs = '0;
        step();

        // Mid-period frequency change takes effect at the wrap.
        pulse_start(0);
        run(1000);
        push(32'h0020_0000);
        check("s4_rdy_low", 32'(fword_rdy), 32'd0);
        for (int i = 0; i < 5000 && wrap !== 1'b1; i++) step();
        check("s4_wrap_seen", 32'(wrap), 32'd1);
        check("s4_rdy_after_wrap", 32'(fword_rdy), 32'd1);
        step();
        check("s4_addr_zero", 32'(rom_addr), 32'd0);
        step();
        check("s4_step_two", 32'(rom_addr), 32'd2);
        pulse_stop();
        wait_idle(5000, "s4_stop_timeout");

        // Burst of 3 periods at 2^22.
        push(32'h0040_0000);
        step();
        pulse_start(3);
        wraps_seen = 0;
        n = 0;
        while (done !== 1'b1 && n < 4000) begin
            step();
            n++;
        end
        check("s5_cycles", 32'(n), 32'd3072);
        check("s5_wraps", 32'(wraps_seen), 32'd3);
        check("s5_busy", 32'(busy), 32'd0);
        step();
        check("s5_acc_cleared", 32'(rom_addr), 32'd0);

        // Zero step: start+stop together starts; stop then ends immediately.
        push(32'h0);
        step();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check("s6_start_wins", 32'(busy), 32'd1);
        run(3);
        pulse_stop();
        check("s6_zero_done", 32'(done), 32'd1);
        check("s6_zero_idle", 32'(busy), 32'd0);

        // Randomized runs against the model.
        for (int it = 0; it < 8; it++) begin
            push($urandom_range(32'h0100_0000, 32'h03FF_FFFF));
            step();
            b = $urandom_range(0, 3);
            stop_at = $urandom_range(100, 700);
            pulse_start(b);
            for (int c = 0; c < 1500 && busy === 1'b1; c++) begin
                poffs = ADDR_W'($urandom);
                fword = $urandom_range(32'h0100_0000, 32'h03FF_FFFF);
                fword_vld = ($urandom_range(0, 31) == 0);
                stop = (c == stop_at);
                step();
            end
            fword_vld = 1'b0;
            stop = 1'b0;
            wait_idle(3000, "s7_idle_timeout");
        end
        poffs = '0;
        step();

        // Asynchronous reset mid-burst with a pending word.
        push(32'h0040_0000);
        step();
        pulse_start(5);
        run(500);
        push(32'h0080_0000);
        check("s8_pending", 32'(fword_rdy), 32'd0);
        run(10);
        rst_n = 1'b0;
        #1;
        check("s8_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("s8_rst_addr_vld", 32'(addr_vld), 32'd0);
        check("s8_rst_q_vld", 32'(q_vld), 32'd0);
        check("s8_rst_busy", 32'(busy), 32'd0);
        check("s8_rst_done", 32'(done), 32'd0);
        check("s8_rst_wrap", 32'(wrap), 32'd0);
        #2 rst_n = 1'b1;
        model_reset();
        check("s8_rdy_release", 32'(fword_rdy), 32'd1);
        run(2);
        push(32'h0010_0000);
        step();
        pulse_start(0);
        run(100);
        pulse_stop();
        wait_idle(5000, "s8_stop_timeout");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
